// File: rtl/host_bus_master.sv
// host_bus_master: initiator for the host register bus (BusMode/Sel/Rd_DS/Wr_RW
// strobes, active-low Rdy_Dtack). Turns single-word read/write requests from a
// local controller into bus cycles and returns read data or a timeout error.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake; req_wr, req_addr, req_wdata payload
//   rsp_valid                one-cycle completion pulse; rsp_rdata, rsp_err
//   BusMode                  constant 1 (Intel-style strobes)
//   Addr, DataIn             bus address / write data (held between cycles)
//   Sel, Rd_DS, Wr_RW        active-low select / read / write strobes
//   DataOut, Rdy_Dtack       responder read data / active-low ack
//
// Optional feature: define HBM_TIMEOUT_EN to add the 16-bit timeout counter
// that aborts a stalled cycle after TMO_CYC strobe cycles with rsp_err=1.
// Without it the strobe phase waits indefinitely and rsp_err stays 0.
module host_bus_master #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned HOLD_CYC = 1,
  parameter int unsigned TMO_CYC  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              BusMode,
  output logic [ADDR_W-1:0] Addr,
  output logic              Sel,
  output logic              Rd_DS,
  output logic              Wr_RW,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              Rdy_Dtack
);

  localparam int unsigned HOLD_W = 4;
  localparam int unsigned TMO_W  = 16;

  // {Sel, Rd_DS, Wr_RW} codes; nothing else is ever driven
  localparam logic [2:0] STB_IDLE = 3'b111;
  localparam logic [2:0] STB_WR   = 3'b010;
  localparam logic [2:0] STB_RD   = 3'b001;

  // Elaboration-time range checks on the timing parameters
  if (HOLD_CYC == 0 || HOLD_CYC > 15) begin : g_bad_hold
    $error("host_bus_master: HOLD_CYC must be 1..15");
  end
  if (TMO_CYC == 0 || TMO_CYC > 65535) begin : g_bad_tmo
    $error("host_bus_master: TMO_CYC must be 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t            state, state_d;
  logic [2:0]        stb, stb_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_in_d;
  logic              req_ready_d;
  logic              rsp_valid_d;
  logic              rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
`ifdef HBM_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
`endif

  assign {Sel, Rd_DS, Wr_RW} = stb;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stb       <= STB_IDLE;
      wr_q      <= 1'b0;
      Addr      <= '0;
      DataIn    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      hold_cnt  <= '0;
      BusMode   <= 1'b1;
`ifdef HBM_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      stb       <= stb_d;
      wr_q      <= wr_d;
      Addr      <= addr_d;
      DataIn    <= data_in_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      hold_cnt  <= hold_cnt_d;
      BusMode   <= 1'b1;
`ifdef HBM_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_d;
`endif
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state;
    stb_d       = stb;
    wr_d        = wr_q;
    addr_d      = Addr;
    data_in_d   = DataIn;
    req_ready_d = req_ready;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;
    hold_cnt_d  = hold_cnt;
`ifdef HBM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          wr_d        = req_wr;
          addr_d      = req_addr;
          data_in_d   = req_wdata;
          req_ready_d = 1'b0;
`ifdef HBM_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
          state_d     = S_SETUP;
        end
      end

      // Address/data already stable; assert the strobe from the next cycle
      S_SETUP: begin
        stb_d   = wr_q ? STB_WR : STB_RD;
        state_d = S_STROBE;
      end

      S_STROBE: begin
        if (!Rdy_Dtack) begin
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end
`ifdef HBM_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
          if (tmo_cnt_d == TMO_W'(TMO_CYC)) begin
            stb_d       = STB_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = S_RECOVER;
          end
        end
`endif
      end

      // Ack deassertion here is ignored; the last hold cycle samples DataOut,
      // giving the registered responder data at least one cycle to settle
      S_HOLD: begin
        if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
          stb_d       = STB_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : DataOut;
          state_d     = S_RECOVER;
        end else begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
        end
      end

      S_RECOVER: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        stb_d       = STB_IDLE;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_host_bus_master.sv
// tb_host_bus_master: directed bench for host_bus_master. Instance A uses
// HOLD_CYC=1/TMO_CYC=8, instance B uses HOLD_CYC=3. Each has a small
// lookup-table responder with a programmable ack delay (A owns the table
// writes, B only reads it).
module tb_host_bus_master;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int NEVER = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid_a = 1'b0;
  logic          req_valid_b = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;

  logic          ready_a, rsp_valid_a, rsp_err_a, busmode_a, sel_a, rd_a, wr_a;
  logic [DW-1:0] rsp_rdata_a, data_in_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] dout_a = '0;
  logic          rdy_a = 1'b1;

  logic          ready_b, rsp_valid_b, rsp_err_b, busmode_b, sel_b, rd_b, wr_b;
  logic [DW-1:0] rsp_rdata_b, data_in_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] dout_b = '0;
  logic          rdy_b = 1'b1;

  host_bus_master #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYC(1), .TMO_CYC(8)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(ready_a), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .BusMode(busmode_a), .Addr(addr_a), .Sel(sel_a), .Rd_DS(rd_a), .Wr_RW(wr_a),
    .DataIn(data_in_a), .DataOut(dout_a), .Rdy_Dtack(rdy_a)
  );

  host_bus_master #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYC(3), .TMO_CYC(255)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(ready_b), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .BusMode(busmode_b), .Addr(addr_b), .Sel(sel_b), .Rd_DS(rd_b), .Wr_RW(wr_b),
    .DataIn(data_in_b), .DataOut(dout_b), .Rdy_Dtack(rdy_b)
  );

  // Lookup-table responders: ack after dly_x strobe cycles, data registered
  logic [DW-1:0] mem [0:4095];
  int dly_a = 0, dly_b = 0, scnt_a = 0, scnt_b = 0;

  always @(negedge clk) begin
    if (!sel_a) begin
      if (scnt_a >= dly_a) begin
        rdy_a = 1'b0;
        if (!wr_a) mem[addr_a] = data_in_a;
        dout_a = mem[addr_a];
      end else begin
        rdy_a = 1'b1;
      end
      scnt_a++;
    end else begin
      scnt_a = 0;
      rdy_a  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!sel_b) begin
      if (scnt_b >= dly_b) begin
        rdy_b  = 1'b0;
        dout_b = mem[addr_b];
      end else begin
        rdy_b = 1'b1;
      end
      scnt_b++;
    end else begin
      scnt_b = 0;
      rdy_b  = 1'b1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one request from the current sample point (cycle 0) and watch it.
  // rsp_cyc stays -1 if no response arrives within budget cycles.
  task automatic do_req(input bit use_b, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int budget,
                        output int n_stb, output int rsp_cyc,
                        output logic [DW-1:0] rdata, output logic err, output int bad);
    logic [2:0] s;
    logic [2:0] exp_s;
    n_stb = 0; rsp_cyc = -1; rdata = '0; err = 1'b0; bad = 0;
    exp_s = wr ? 3'b010 : 3'b001;
    req_wr = wr; req_addr = addr; req_wdata = wd;
    if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    for (int c = 1; c <= budget && rsp_cyc < 0; c++) begin
      @(posedge clk); #1;
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      s = use_b ? {sel_b, rd_b, wr_b} : {sel_a, rd_a, wr_a};
      if (s != 3'b111) begin
        n_stb++;
        if (s != exp_s) bad++;
      end
      if (use_b ? rsp_valid_b : rsp_valid_a) begin
        rsp_cyc = c;
        rdata   = use_b ? rsp_rdata_b : rsp_rdata_a;
        err     = use_b ? rsp_err_b : rsp_err_a;
      end
    end
  endtask

  int n_stb, rsp_cyc, bad;
  logic [DW-1:0] rdata;
  logic err;

  // Back-to-back stimulus
  logic          bb_wr   [3] = '{1'b1, 1'b0, 1'b1};
  logic [AW-1:0] bb_addr [3] = '{12'h100, 12'h012, 12'h101};
  logic [DW-1:0] bb_wd   [3] = '{16'h0111, 16'h0000, 16'h0222};
  logic [DW-1:0] bb_exp  [3] = '{16'h0000, 16'h0ABC, 16'h0000};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", 32'({sel_a, rd_a, wr_a}), 32'h7);
    check("rst_busmode", 32'({busmode_a, busmode_b}), 32'h3);
    check("rst_addr_data", 32'({addr_a, data_in_a}), 32'h0);
    check("rst_ready", 32'(ready_a), 32'h1);
    check("rst_rsp", 32'({rsp_valid_a, rsp_err_a, rsp_rdata_a}), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write 0x0ABC to 0x012, immediate ack
    dly_a = 0;
    do_req(1'b0, 1'b1, 12'h012, 16'h0ABC, 50, n_stb, rsp_cyc, rdata, err, bad);
    check("wr_rsp_cycle", 32'(rsp_cyc), 32'd4);
    check("wr_strobe_cycles", 32'(n_stb), 32'd2);
    check("wr_strobe_code", 32'(bad), 32'd0);
    check("wr_err_rdata", 32'({err, rdata}), 32'h0);
    check("wr_addr_hold", 32'(addr_a), 32'h012);
    check("wr_datain_hold", 32'(data_in_a), 32'h0ABC);
    check("wr_mem", 32'(mem[12'h012]), 32'h0ABC);
    check("wr_ready_low_in_rsp", 32'(ready_a), 32'h0);
    @(posedge clk); #1;
    check("wr_ready_after", 32'(ready_a), 32'h1);

    // Read it back
    do_req(1'b0, 1'b0, 12'h012, 16'h0000, 50, n_stb, rsp_cyc, rdata, err, bad);
    check("rd_rsp_cycle", 32'(rsp_cyc), 32'd4);
    check("rd_strobe", 32'({n_stb[7:0], 8'(bad)}), 32'h0200);
    check("rd_rdata", 32'(rdata), 32'h0ABC);
    check("rd_err", 32'(err), 32'h0);
    @(posedge clk); #1;

    // Slow ack on B: 5-cycle delay, HOLD_CYC=3
    dly_b = 5;
    do_req(1'b1, 1'b0, 12'h012, 16'h0000, 50, n_stb, rsp_cyc, rdata, err, bad);
    check("slow_strobe_cycles", 32'(n_stb), 32'd9);
    check("slow_rsp_cycle", 32'(rsp_cyc), 32'd11);
    check("slow_rdata", 32'(rdata), 32'h0ABC);
    check("slow_code_err", 32'({bad[7:0], 7'b0, err}), 32'h0);
    @(posedge clk); #1;

    // Slow ack on A: 5-cycle delay, HOLD_CYC=1
    dly_a = 5;
    do_req(1'b0, 1'b1, 12'h020, 16'h0F0F, 50, n_stb, rsp_cyc, rdata, err, bad);
    check("slowA_strobe_cycles", 32'(n_stb), 32'd7);
    check("slowA_rsp_cycle", 32'(rsp_cyc), 32'd9);
    @(posedge clk); #1;

    // Stalled responder
    dly_a = NEVER;
`ifdef HBM_TIMEOUT_EN
    do_req(1'b0, 1'b0, 12'h030, 16'h0000, 50, n_stb, rsp_cyc, rdata, err, bad);
    check("tmo_strobe_cycles", 32'(n_stb), 32'd8);
    check("tmo_rsp_cycle", 32'(rsp_cyc), 32'd10);
    check("tmo_err", 32'(err), 32'h1);
    check("tmo_rdata", 32'(rdata), 32'h0);
    @(posedge clk); #1;
`else
    do_req(1'b0, 1'b0, 12'h030, 16'h0000, 1000, n_stb, rsp_cyc, rdata, err, bad);
    check("stall_no_rsp", 32'(rsp_cyc), 32'hFFFF_FFFF);
    check("stall_strobe_cycles", 32'(n_stb), 32'd999);
    check("stall_err", 32'(rsp_err_a), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
`endif
    dly_a = 0;

    // Back-to-back: valid held high across three requests
    begin
      int n_acc = 0, n_rsp = 0, bad_ready = 0, idle_run = 0, min_gap = 1000;
      bit outstanding = 1'b0, seen = 1'b0, acc_now;
      logic [2:0] s;
      req_wr = bb_wr[0]; req_addr = bb_addr[0]; req_wdata = bb_wd[0];
      req_valid_a = 1'b1;
      for (int c = 0; c < 60 && n_rsp < 3; c++) begin
        if (outstanding && ready_a) bad_ready++;
        if (rsp_valid_a) begin
          check($sformatf("b2b_rdata%0d", n_rsp), 32'(rsp_rdata_a), 32'(bb_exp[n_rsp]));
          n_rsp++;
          outstanding = 1'b0;
        end
        s = {sel_a, rd_a, wr_a};
        if (s != 3'b111) begin
          if (seen && idle_run > 0 && idle_run < min_gap) min_gap = idle_run;
          seen = 1'b1;
          idle_run = 0;
        end else begin
          idle_run++;
        end
        acc_now = req_valid_a && ready_a;
        @(posedge clk); #1;
        if (acc_now) begin
          outstanding = 1'b1;
          n_acc++;
          if (n_acc < 3) begin
            req_wr = bb_wr[n_acc]; req_addr = bb_addr[n_acc]; req_wdata = bb_wd[n_acc];
          end else begin
            req_valid_a = 1'b0;
          end
        end
      end
      req_valid_a = 1'b0;
      check("b2b_rsp_count", 32'(n_rsp), 32'd3);
      check("b2b_ready_low", 32'(bad_ready), 32'd0);
      check("b2b_min_gap", 32'(min_gap), 32'd3);
      check("b2b_mem", 32'({mem[12'h100], mem[12'h101]}), 32'h0111_0222);
      check("b2b_addr_hold", 32'({4'h0, addr_a, data_in_a}), 32'h0101_0222);
    end
    @(posedge clk); #1;

    // Reset in the middle of the strobe phase
    begin
      int n_rsp = 0;
      dly_a = NEVER;
      req_wr = 1'b1; req_addr = 12'h040; req_wdata = 16'h0BAD;
      req_valid_a = 1'b1;
      @(posedge clk); #1;
      req_valid_a = 1'b0;
      @(posedge clk); #1;
      check("mid_strobe_active", 32'({sel_a, rd_a, wr_a}), 32'h2);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_strobes", 32'({sel_a, rd_a, wr_a}), 32'h7);
      @(posedge clk); #1;
      rst = 1'b0;
      dly_a = 0;
      for (int c = 0; c < 6; c++) begin
        if (rsp_valid_a) n_rsp++;
        @(posedge clk); #1;
      end
      check("mid_rst_no_rsp", 32'(n_rsp), 32'd0);
      check("mid_rst_ready", 32'(ready_a), 32'h1);
      do_req(1'b0, 1'b1, 12'h050, 16'h1234, 50, n_stb, rsp_cyc, rdata, err, bad);
      check("post_rst_rsp_cycle", 32'(rsp_cyc), 32'd4);
      check("post_rst_mem", 32'(mem[12'h050]), 32'h1234);
    end
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/host_bus_master.md
Name: host_bus_master

Overview:
- Initiator side of the host register bus (BusMode/Sel/Rd_DS/Wr_RW strobes, active-low Rdy_Dtack).
- Converts single-word read/write requests from a local controller into bus cycles toward lookup-table responders.
- Returns read data or a timeout error per request.
- Intended uses: table preload, CPU-less bring-up and bench stimulus.

Parameters:
- ADDR_W, 12, bus address width.
- DATA_W, 16, bus data width; set to 12+CHANNEL_NUM at instantiation.
- HOLD_CYC, 1, cycles strobes stay asserted after Rdy_Dtack is seen low; legal range 1..15.
- TMO_CYC, 255, maximum cycles to wait for Rdy_Dtack low; legal range 1..65535.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  captured read data; 0 for writes and errors.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- BusMode  out  1  constant 1 (Intel-style strobes).
- Addr  out  ADDR_W  bus address.
- Sel  out  1  bus select, active low.
- Rd_DS  out  1  read strobe, active low.
- Wr_RW  out  1  write strobe, active low.
- DataIn  out  DATA_W  bus write data (responder input).
- DataOut  in  DATA_W  bus read data (responder output).
- Rdy_Dtack  in  1  responder ack, active low.

Behaviour:
- All outputs are registered.
- Reset values: Sel=Rd_DS=Wr_RW=1, BusMode=1, Addr=0, DataIn=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. FSM=IDLE, counters=0.
- Strobe encoding {Sel,Rd_DS,Wr_RW}: idle=111, write=010, read=001. No other code is ever driven.
- IDLE:
  - req_ready=1.
  - On accept, latch req_wr/addr/wdata, drive Addr/DataIn, set req_ready=0, go SETUP.
- SETUP (1 cycle):
  - Strobes stay 111; address and data are stable before the strobe.
  - Go STROBE.
- STROBE:
  - Drive 010 (write) or 001 (read).
  - Rdy_Dtack is sampled each cycle starting from the first STROBE cycle.
  - On Rdy_Dtack==0, clear hold counter and go HOLD.
  - Else increment the timeout counter. When the counter reaches TMO_CYC, go RECOVER with err=1.
- HOLD:
  - Strobes stay asserted for HOLD_CYC cycles.
  - On the last HOLD cycle, a read captures DataOut into rsp_rdata. Responder read data is registered, so at least 1 cycle after the ack is required.
  - Go RECOVER.
  - If Rdy_Dtack deasserts during HOLD: ignore it and complete normally.
- RECOVER (1 cycle):
  - Strobes return to 111.
  - Pulse rsp_valid=1 with rsp_err. rsp_rdata=0 for writes and errors.
  - Go IDLE. req_ready rises the cycle after rsp_valid.
- Minimum request-to-response latency: accept at cycle 0, then SETUP, STROBE, HOLD_CYC, RECOVER. With HOLD_CYC=1 and immediate ack, rsp_valid is seen in cycle 4.
- At most one request is outstanding. Back-to-back requests always have at least 2 idle-strobe cycles between strobe periods.
- Addr and DataIn hold their last values after a cycle completes; they change only on request accept.
- Reset asserted mid-cycle: strobes return to 111 asynchronously and no rsp_valid is generated. The request is lost and the controller must reissue.
- Rdy_Dtack low while in IDLE or SETUP is ignored.
- Timeout counter width is 16 bits; it is cleared on accept.

Optional Feature:
- Macro: HBM_TIMEOUT_EN.
- Defined: timeout counter present; a stalled cycle aborts after TMO_CYC cycles with rsp_err=1.
- Undefined: no counter; STROBE waits indefinitely for Rdy_Dtack; rsp_err is tied 0; TMO_CYC is unused.

Test Plan:
- Write: req_wr=1, addr=0x012, wdata=0x0ABC; responder acks on first STROBE cycle -> Sel/Rd_DS/Wr_RW=010 for 2 cycles, Addr=0x012, DataIn=0x0ABC, rsp_valid pulse at cycle 4, rsp_err=0.
- Read after write: read addr 0x012 from a lookup-table responder -> strobes 001, rsp_rdata=0x0ABC, rsp_err=0.
- Slow ack: responder delays Rdy_Dtack low by 5 cycles, HOLD_CYC=3 -> strobes asserted 9 cycles, rsp_valid at cycle 11.
- Timeout (HBM_TIMEOUT_EN, TMO_CYC=8): Rdy_Dtack held 1 -> strobes drop after 8 STROBE cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0. Without the macro: no response after 1000 cycles.
- Back-to-back: req_valid held high for 3 requests -> req_ready low during each, at least 2 cycles of 111 between strobe periods, 3 rsp_valid pulses in order.
- Reset mid-STROBE: assert rst during STROBE -> strobes 111 in the same cycle, no rsp_valid; after release, req_ready=1 and a new request completes normally.
